uart_rx_avs: RTL and testbench

Fabric-side UART receiver with a 16x-oversampled bit engine, a byte FIFO and an Avalon-MM slave. It is instantiated inside the Platform Designer system on the HPS lightweight bridge. The HPS UART0 TX pin is looped into the fabric for console capture, and the HPS software drains received bytes by polling or by interrupt. This block is the receiving end of the serial link the HPS transmits on.

---
 rtl/uart_rx_pkg.sv | 31 +++
 rtl/uart_rx_avs_if.sv | 20 ++
 rtl/byte_fifo.sv | 45 ++++
 rtl/uart_rx_avs.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_avs.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the fabric-side UART receiver:
// engine states, register addresses, STATUS bit positions and the divider helper.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVR   = 2;
    localparam int STAT_FERR  = 3;
    localparam int STAT_COUNT = 8;

    // Clocks per 16x oversample tick, rounded to nearest and never below 1.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = (clk_hz + baud * 8) / (baud * 16);
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage

// File: rtl/uart_rx_avs_if.sv
// Avalon-MM slave bus of the receiver, as seen from the HPS lightweight bridge.
// Handshake: avs_read/avs_write are single-cycle strobes with no waitrequest;
// avs_readdata is valid exactly one clock after the cycle avs_read was high.
interface uart_rx_avs_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/byte_fifo.sv
// Circular byte buffer with one extra pointer bit to tell full from empty.
// A push into a full buffer succeeds only when a pop frees a slot in the same cycle.
module byte_fifo #(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [7:0]  din,
    input  logic        pop,
    output logic [7:0]  dout,
    output logic        empty,
    output logic        full,
    output logic [AW:0] count
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_pop;
    logic        do_push;

    assign count   = wptr - rptr;
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_avs.sv
// 16x-oversampled UART receiver feeding a byte FIFO, drained by the HPS over Avalon-MM.
// Sticky OVR/FERR flags, IEN-gated level interrupt, engine state on fsm_state.
module uart_rx_avs
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx,
    uart_rx_avs_if.slave   avs,
    output logic           irq,
    output uart_state_t    fsm_state
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    logic rx_m, rx_s, rx_s_d, fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            rx_m   <= rx;
            rx_s   <= rx_m;
            rx_s_d <= rx_s;
        end
    end

    assign fall = rx_s_d & ~rx_s;

    uart_state_t      state, state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             tick, mid, restart, shift_en, push, ferr_set;

    assign tick = (div_cnt == DIV_W'(DIV - 1));
    // tick_cnt wraps every 16 ticks, so mid-bit is the same count in every bit.
    assign mid  = tick && (tick_cnt == 4'd7);

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)     tick_cnt <= tick_cnt + 1'b1;
            if (shift_en) bit_cnt  <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)         shift_reg <= '0;
        else if (shift_en) shift_reg <= {rx_s, shift_reg[7:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        shift_en  = 1'b0;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                    restart   = 1'b1;
                end
            end
            START: begin
                if (mid) state_nxt = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (mid) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (mid) begin
                    if (rx_s) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fsm_state = state;

    logic [7:0]    fifo_dout;
    logic          fifo_empty, fifo_full, pop;
    logic [CW-1:0] fifo_count;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (shift_reg),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    logic        rd, wr, ovr, ferr, ien, ovr_set, ovr_clr, ferr_clr;
    logic [31:0] rd_mux, readdata_q;
    logic        unused_wdata;

    assign rd       = avs.avs_read;
    assign wr       = avs.avs_write & ~avs.avs_read;
    assign pop      = rd && (avs.avs_address == ADDR_DATA);
    // A pop in the same cycle frees the slot, so a full-buffer push is then not an overrun.
    assign ovr_set  = push & fifo_full & ~pop;
    assign ovr_clr  = wr && (avs.avs_address == ADDR_STATUS) && avs.avs_writedata[STAT_OVR];
    assign ferr_clr = wr && (avs.avs_address == ADDR_STATUS) && avs.avs_writedata[STAT_FERR];
    assign unused_wdata = ^{avs.avs_writedata[31:4], avs.avs_writedata[1]};

    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            ADDR_DATA: begin
                rd_mux[8]   = ~fifo_empty;
                rd_mux[7:0] = fifo_empty ? 8'h00 : fifo_dout;
            end
            ADDR_STATUS: begin
                rd_mux[STAT_EMPTY]         = fifo_empty;
                rd_mux[STAT_FULL]          = fifo_full;
                rd_mux[STAT_OVR]           = ovr;
                rd_mux[STAT_FERR]          = ferr;
                rd_mux[STAT_COUNT +: CW]   = fifo_count;
            end
            ADDR_CTRL: rd_mux[0] = ien;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovr        <= 1'b0;
            ferr       <= 1'b0;
            ien        <= 1'b0;
            irq        <= 1'b0;
            readdata_q <= '0;
        end else begin
            if (ovr_set)      ovr  <= 1'b1;
            else if (ovr_clr) ovr  <= 1'b0;
            if (ferr_set)      ferr <= 1'b1;
            else if (ferr_clr) ferr <= 1'b0;
            if (wr && (avs.avs_address == ADDR_CTRL)) ien <= avs.avs_writedata[0];
            irq <= ien & (~fifo_empty | ovr | ferr);
            if (rd) readdata_q <= rd_mux;
        end
    end

    assign avs.avs_readdata = readdata_q;

endmodule

// File: tb/tb_uart_rx_avs.sv
// Directed bench for uart_rx_avs at 16 clocks per bit; register reads are
// scored by a monitor popping hand-computed expectations from exp_q.
module tb_uart_rx_avs;
    import uart_rx_pkg::*;

    localparam int CLK_HZ   = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int DEPTH    = 16;
    localparam int BIT_CLKS = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        irq;
    uart_state_t fsm_state;

    uart_rx_avs_if bus();

    uart_rx_avs #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .avs       (bus),
        .irq       (irq),
        .fsm_state (fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: got no end of test, want end within 2ms");
        $fatal(1, "timeout");
    end

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // scoreboard monitor: every read strobe yields one readdata word next cycle
    initial begin
        forever begin
            @(posedge clk);
            if (bus.avs_read === 1'b1) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_read: got 0x%0h, want no read", bus.avs_readdata);
                end else begin
                    check(name_q.pop_front(), bus.avs_readdata, exp_q.pop_front());
                end
            end
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_level(input logic v, input int n);
        rx = v;
        idle(n);
    endtask

    task automatic send_data(input logic [7:0] b);
        rx_level(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) rx_level(b[i], BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_data(b);
        rx_level(1'b1, BIT_CLKS);
    endtask

    task automatic avs_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        idle(1);
        bus.avs_read    = 1'b0;
    endtask

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        idle(1);
        bus.avs_write     = 1'b0;
    endtask

    initial begin
        int n;
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        idle(4);
        reset = 1'b0;

        check("rst_readdata", bus.avs_readdata, 32'h0);
        check("rst_irq", irq, 1'b0);
        check("rst_state", fsm_state, IDLE);
        avs_rd(ADDR_STATUS, 32'h1, "rst_status");
        avs_rd(ADDR_CTRL, 32'h0, "rst_ctrl");
        avs_rd(2'd3, 32'h0, "addr3_zero");

        // single frame
        send_frame(8'h55);
        idle(2);
        avs_rd(ADDR_DATA, 32'h155, "rx_55");
        avs_rd(ADDR_STATUS, 32'h1, "status_after_55");
        avs_rd(ADDR_DATA, 32'h0, "read_when_empty");

        // overflow: 17 frames into 16 entries, then back-to-back drain
        for (int i = 0; i < 17; i++) send_frame(8'(i));
        idle(2);
        avs_rd(ADDR_STATUS, 32'h1006, "full_ovr_status");
        for (int i = 0; i < 16; i++) avs_rd(ADDR_DATA, 32'h100 | i, $sformatf("drain_%0d", i));
        avs_rd(ADDR_DATA, 32'h0, "drain_17th_invalid");
        avs_rd(ADDR_STATUS, 32'h5, "ovr_sticky");

        // framing error with stop bit held low for 3 bits
        send_data(8'hA3);
        rx_level(1'b0, 40);
        check("break_held", fsm_state, BREAK);
        rx_level(1'b0, 8);
        rx_level(1'b1, BIT_CLKS);
        check("break_exit", fsm_state, IDLE);
        avs_rd(ADDR_STATUS, 32'hD, "ferr_status");
        send_frame(8'h3C);
        idle(2);
        avs_rd(ADDR_DATA, 32'h13C, "rx_3c_after_break");

        // flag clear, then a short glitch must leave nothing behind
        avs_wr(ADDR_STATUS, 32'h0C);
        avs_rd(ADDR_STATUS, 32'h1, "flags_cleared");
        rx_level(1'b0, 4);
        rx_level(1'b1, 40);
        check("glitch_state", fsm_state, IDLE);
        avs_rd(ADDR_STATUS, 32'h1, "glitch_status");

        // interrupt: rises one clock after the byte lands, falls one clock after the drain
        avs_wr(ADDR_CTRL, 32'h1);
        avs_rd(ADDR_CTRL, 32'h1, "ien_readback");
        check("irq_idle_empty", irq, 1'b0);
        send_data(8'h7E);
        rx = 1'b1;
        n = 0;
        while (irq !== 1'b1 && n < 30) begin
            idle(1);
            n++;
        end
        check("irq_rise_clocks", n, 12);
        idle(10);
        avs_rd(ADDR_DATA, 32'h17E, "rx_7e");
        check("irq_hold_at_pop", irq, 1'b1);
        idle(1);
        check("irq_fall", irq, 1'b0);

        // reset at mid-bit 4 of 0xFF
        fork
            send_frame(8'hFF);
            begin
                idle(88);
                reset = 1'b1;
                idle(2);
                reset = 1'b0;
                check("midframe_rst_irq", irq, 1'b0);
                check("midframe_rst_readdata", bus.avs_readdata, 32'h0);
                check("midframe_rst_state", fsm_state, IDLE);
            end
        join
        idle(40);
        avs_rd(ADDR_STATUS, 32'h1, "post_reset_status");
        avs_rd(ADDR_CTRL, 32'h0, "post_reset_ctrl");
        avs_rd(ADDR_DATA, 32'h0, "no_spurious_byte");
        check("post_reset_irq", irq, 1'b0);

        // final report
        idle(3);
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
